// File: rtl/fp_norm_round106.sv
// Two-stage normalize-and-round: leading-zero count, left shift, round to MW bits.
// Optional directed rounding modes via `FP_NORM_ROUND_MODES_EN (adds rm[1:0]).
module fp_norm_round106 #(
  parameter int M  = 106,
  parameter int MW = 53,
  parameter int EW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  mag,
  input  logic [EW-1:0] exp_in,
  input  logic          sign_in,
`ifdef FP_NORM_ROUND_MODES_EN
  input  logic [1:0]    rm,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] mant,
  output logic [EW-1:0] exp_out,
  output logic          sign_out,
  output logic          zero,
  output logic          inexact
);

  localparam int LW = $clog2(M + 1);

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_t;

  function automatic logic [LW-1:0] f_lzc(input logic [M-1:0] v);
    logic found;
    f_lzc = LW'(M);
    found = 1'b0;
    for (int unsigned i = 0; i < M; i++) begin
      if (!found && v[M-1-i]) begin
        f_lzc = LW'(i);
        found = 1'b1;
      end
    end
  endfunction

  logic          r1_valid;
  logic [M-1:0]  r1_mag;
  logic [LW-1:0] r1_lzc;
  logic [EW-1:0] r1_exp;
  logic          r1_sign;
  logic          r1_zero;
  rmode_t        r1_rm;

  logic          w_s1_adv;
  rmode_t        w_rm_in;

  assign w_s1_adv = !out_valid || out_ready;
  assign in_ready = !r1_valid || w_s1_adv;

`ifdef FP_NORM_ROUND_MODES_EN
  assign w_rm_in = rmode_t'(rm);
`else
  assign w_rm_in = RM_RNE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_mag   <= '0;
      r1_lzc   <= '0;
      r1_exp   <= '0;
      r1_sign  <= 1'b0;
      r1_zero  <= 1'b0;
      r1_rm    <= RM_RNE;
    end else if (in_ready) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_mag  <= mag;
        r1_lzc  <= f_lzc(mag);
        r1_exp  <= exp_in;
        r1_sign <= sign_in;
        r1_zero <= (mag == '0);
        r1_rm   <= w_rm_in;
      end
    end
  end

  logic [M-1:0]  w_sh;
  logic [MW-1:0] w_trunc;
  logic          w_guard;
  logic          w_sticky;
  logic          w_inexact;
  logic          w_inc;
  logic [MW:0]   w_sum;
  logic [EW-1:0] w_exp_base;
  logic [MW-1:0] w_mant;
  logic [EW-1:0] w_exp;

  always_comb begin
    w_sh       = r1_mag << r1_lzc;
    w_trunc    = w_sh[M-1 -: MW];
    w_guard    = w_sh[M-MW-1];
    w_sticky   = |w_sh[M-MW-2:0];
    w_inexact  = w_guard | w_sticky;
    w_inc      = 1'b0;
    unique case (r1_rm)
      RM_RNE:  w_inc = w_guard & (w_sticky | w_trunc[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = w_inexact & !r1_sign;
      RM_RDN:  w_inc = w_inexact & r1_sign;
      default: w_inc = 1'b0;
    endcase
    w_sum      = {1'b0, w_trunc} + {{MW{1'b0}}, w_inc};
    w_exp_base = r1_exp + EW'(1) - EW'(r1_lzc);
    // A carry out of the increment means the significand became 2.0: renormalize.
    if (w_sum[MW]) begin
      w_mant = {1'b1, {(MW-1){1'b0}}};
      w_exp  = w_exp_base + EW'(1);
    end else begin
      w_mant = w_sum[MW-1:0];
      w_exp  = w_exp_base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      mant      <= '0;
      exp_out   <= '0;
      sign_out  <= 1'b0;
      zero      <= 1'b0;
      inexact   <= 1'b0;
    end else if (w_s1_adv) begin
      out_valid <= r1_valid;
      if (r1_valid) begin
        sign_out <= r1_sign;
        zero     <= r1_zero;
        mant     <= r1_zero ? '0 : w_mant;
        exp_out  <= r1_zero ? '0 : w_exp;
        inexact  <= r1_zero ? 1'b0 : w_inexact;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round106.sv
// Bench for fp_norm_round106: directed vector table, back-pressure and reset
// sequences, then randomized traffic against an arithmetic reference model.
module tb_fp_norm_round106;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [105:0] mag = '0;
  logic [12:0]  exp_in = '0;
  logic         sign_in = 1'b0;
  logic [1:0]   rm = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [52:0]  mant;
  logic [12:0]  exp_out;
  logic         sign_out;
  logic         zero;
  logic         inexact;

  always #5 clk = ~clk;

  fp_norm_round106 #(.M(106), .MW(53), .EW(13)) dut (
`ifdef FP_NORM_ROUND_MODES_EN
    .rm(rm),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mag(mag), .exp_in(exp_in), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant(mant), .exp_out(exp_out), .sign_out(sign_out),
    .zero(zero), .inexact(inexact)
  );

  typedef struct packed {
    logic [52:0] mant;
    logic [12:0] ex;
    logic        sign;
    logic        zero;
    logic        inexact;
  } res_t;

  typedef struct {
    logic [105:0] mag;
    logic [12:0]  ex;
    logic         sign;
    res_t         want;
  } vec_t;

  res_t q[$];
  res_t exp_next;
  int   checks = 0;
  int   errors = 0;
  logic accepted = 1'b0;
  logic rand_bp = 1'b0;

  function automatic res_t mk(logic [52:0] m, logic [12:0] e, logic s, logic z, logic x);
    res_t r;
    r.mant = m; r.ex = e; r.sign = s; r.zero = z; r.inexact = x;
    return r;
  endfunction

  // Reference: locate the MSB, split into kept bits and remainder, compare remainder to half-ulp.
  function automatic res_t model(logic [105:0] m, logic [12:0] e, logic s, logic [1:0] mode);
    res_t r;
    int p, k;
    logic [105:0] sig, rem, half;
    logic up, inx;
    r.sign = s;
    if (m == '0) begin
      r.mant = '0; r.ex = '0; r.zero = 1'b1; r.inexact = 1'b0;
      return r;
    end
    p = 0;
    for (int i = 0; i < 106; i++) if (m[i]) p = i;
    if (p >= 52) begin
      k = p - 52;
      sig = m >> k;
      rem = m & ((106'd1 << k) - 106'd1);
      half = (k > 0) ? (106'd1 << (k - 1)) : 106'd0;
    end else begin
      sig = m << (52 - p);
      rem = '0;
      half = '0;
    end
    inx = (rem != '0);
    case (mode)
      2'b00:   up = inx && ((rem > half) || (rem == half && sig[0]));
      2'b01:   up = 1'b0;
      2'b10:   up = inx && !s;
      default: up = inx && s;
    endcase
    sig = sig + 106'(up);
    if (sig[53]) begin
      sig = sig >> 1;
      p++;
    end
    r.mant = sig[52:0];
    r.ex = e + 13'(p - 104);
    r.zero = 1'b0;
    r.inexact = inx;
    return r;
  endfunction

  function automatic res_t get_out();
    return mk(mant, exp_out, sign_out, zero, inexact);
  endfunction

  task automatic check(string name, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic at_neg();
    res_t w;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (accepted) q.push_back(exp_next);
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", 128'd1, 128'd0);
      else begin
        w = q.pop_front();
        check("out_data", 128'(get_out()), 128'(w));
      end
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom % 4) != 0;
  endtask

  task automatic step();
    at_neg();
    to_pos();
  endtask

  task automatic apply(vec_t v);
    mag = v.mag; exp_in = v.ex; sign_in = v.sign;
    exp_next = v.want;
    in_valid = 1'b1;
  endtask

  task automatic send(vec_t v);
    int n;
    apply(v);
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 200);
    if (!accepted) check("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 1000) begin
      step();
      n++;
    end
    check("drain_timeout", 128'(q.size()), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    logic [52:0] h;
    logic [105:0] one;
    int p;

    h = 53'd1 << 52;
    one = 106'd1;
    tbl[0] = '{one << 104, 13'd0, 1'b0, mk(h, 13'd0, 0, 0, 0)};
    tbl[1] = '{one << 105, 13'd5, 1'b0, mk(h, 13'd6, 0, 0, 0)};
    tbl[2] = '{(one << 104) | (one << 52) | (one << 51), 13'd0, 1'b0, mk(h + 53'd2, 13'd0, 0, 0, 1)};
    tbl[3] = '{(one << 104) | (one << 51), 13'd0, 1'b0, mk(h, 13'd0, 0, 0, 1)};
    tbl[4] = '{((one << 54) - one) << 51, 13'd0, 1'b0, mk(h, 13'd1, 0, 0, 1)};
    tbl[5] = '{106'd0, 13'd100, 1'b1, mk(53'd0, 13'd0, 1, 1, 0)};
    tbl[6] = '{one, 13'd0, 1'b0, mk(h, 13'h1F98, 0, 0, 0)};
    tbl[7] = '{'1, 13'd0, 1'b1, mk(h, 13'd2, 1, 0, 1)};
    tbl[8] = '{one << 105, 13'h0FFF, 1'b0, mk(h, 13'h1000, 0, 0, 0)};
    tbl[9] = '{(one << 104) | (one << 51) | one, 13'd0, 1'b0, mk(h + 53'd1, 13'd0, 0, 0, 1)};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_fields", 128'(get_out()), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;

    // directed table at full throughput
    for (int i = 0; i < 10; i++) send(tbl[i]);
    drain();

    // back-pressure: A, B accepted, C stalls, A held, then A B C stream out
    out_ready = 1'b0;
    apply(tbl[0]);
    at_neg(); check("bp_accept_A", 128'(accepted), 128'd1); to_pos();
    apply(tbl[1]);
    at_neg(); check("bp_accept_B", 128'(accepted), 128'd1); to_pos();
    apply(tbl[2]);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("bp_in_ready_low", 128'(in_ready), 128'd0);
      check("bp_hold_valid", 128'(out_valid), 128'd1);
      check("bp_hold_data", 128'(get_out()), 128'(tbl[0].want));
      to_pos();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("bp_stream_valid", 128'(out_valid), 128'd1);
      to_pos();
      in_valid = 1'b0;
    end
    drain();

    // reset with two beats in flight
    send(tbl[3]);
    send(tbl[4]);
    in_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    at_neg();
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    to_pos();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      check("midrst_no_stale", 128'(out_valid), 128'd0);
      to_pos();
    end

    // randomized traffic with random back-pressure and input gaps
    rand_bp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom % 8)
        0: v.mag = '0;
        1: begin
          p = $urandom_range(53, 105);
          v.mag = (one << p) | (one << (p - 53));
          if ($urandom % 2) v.mag = v.mag | (one << (p - 52));
        end
        default: begin
          v.mag = 106'({$urandom, $urandom, $urandom, $urandom});
          v.mag = v.mag >> ($urandom % 107);
        end
      endcase
      v.ex = 13'($urandom);
      v.sign = 1'($urandom);
`ifdef FP_NORM_ROUND_MODES_EN
      rm = 2'($urandom);
`endif
      v.want = model(v.mag, v.ex, v.sign, rm);
      send(v);
      if ($urandom % 4 == 0) begin
        in_valid = 1'b0;
        step();
      end
    end
    drain();
    rand_bp = 1'b0;
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
